// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and
// small helpers used by the transmit controller.
package uart_pkg;

  // Transmitter sequencing states, one per section of the serial frame.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Parity mode encoding as it appears on the configuration port.
  // The fourth code (2'b11) is not listed and behaves like PAR_NONE.
  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } par_mode_e;

  // True when the latched mode asks for a parity bit on the line.
  function automatic logic has_parity(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Parity bit for a byte: even mode sends the XOR of the data bits,
  // odd mode sends its inverse.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between a requester and the UART transmit controller.
interface uart_tx_ctrl_if;

  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;

  // The requester offers bytes and watches ready.
  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  // The transmit controller accepts bytes and drives ready.
  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: one-entry holding register in front of a
// start/data/parity/stop sequencer paced by an external 1x baud tick.
// A byte held while a frame is on the line starts right after the last
// stop tick, so back-to-back frames have no idle gap.
module uart_tx_ctrl
  import uart_pkg::*;
(
  input  logic          clk,
  input  logic          arst_n,
  uart_tx_ctrl_if.slave s,
  input  logic [1:0]    cfg_parity,
  input  logic          cfg_stop2,
  input  logic          baud_tick,
  output logic          baud_active,
  output logic          txd,
  output logic          busy,
  output logic          frame_done
);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic [1:0] par_mode_q, par_mode_d;
  logic       par_bit_q, par_bit_d;
  logic       stop2_q, stop2_d;

  logic [7:0] hold_data_q, hold_data_d;
  logic [1:0] hold_parity_q, hold_parity_d;
  logic       hold_stop2_q, hold_stop2_d;
  logic       hold_full_q, hold_full_d;

  logic       txd_q, txd_d;
  logic       baud_active_q, baud_active_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;

  logic       load_frame;

  // Ready depends only on the holding register flop, never on s_valid.
  assign s.s_ready   = !hold_full_q;
  assign txd         = txd_q;
  assign baud_active = baud_active_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;

  // Next-state logic: accept into the holding register, advance the frame on
  // baud ticks, and precompute every output from the state being entered.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    stop_cnt_d    = stop_cnt_q;
    par_mode_d    = par_mode_q;
    par_bit_d     = par_bit_q;
    stop2_d       = stop2_q;
    hold_data_d   = hold_data_q;
    hold_parity_d = hold_parity_q;
    hold_stop2_d  = hold_stop2_q;
    hold_full_d   = hold_full_q;
    frame_done_d  = 1'b0;
    load_frame    = 1'b0;

    if (s.s_valid && !hold_full_q) begin
      hold_data_d   = s.s_data;
      hold_parity_d = cfg_parity;
      hold_stop2_d  = cfg_stop2;
      hold_full_d   = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        load_frame = hold_full_q;
      end
      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d    = has_parity(par_mode_q) ? PARITY : STOP;
            stop_cnt_d = 1'b0;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            frame_done_d = 1'b1;
            if (hold_full_q) begin
              load_frame = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_frame) begin
      state_d     = START;
      shift_d     = hold_data_q;
      par_mode_d  = hold_parity_q;
      par_bit_d   = parity_bit(hold_data_q, hold_parity_q);
      stop2_d     = hold_stop2_q;
      bit_cnt_d   = 3'd0;
      stop_cnt_d  = 1'b0;
      hold_full_d = 1'b0;
    end

    case (state_d)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = par_bit_d;
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase

    baud_active_d = (state_d != IDLE);
    busy_d        = (state_d != IDLE) || hold_full_d;
  end

  // State, datapath and registered outputs; reset drops any frame in flight.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= IDLE;
      shift_q       <= 8'd0;
      bit_cnt_q     <= 3'd0;
      stop_cnt_q    <= 1'b0;
      par_mode_q    <= 2'b00;
      par_bit_q     <= 1'b0;
      stop2_q       <= 1'b0;
      hold_data_q   <= 8'd0;
      hold_parity_q <= 2'b00;
      hold_stop2_q  <= 1'b0;
      hold_full_q   <= 1'b0;
      txd_q         <= 1'b1;
      baud_active_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      stop_cnt_q    <= stop_cnt_d;
      par_mode_q    <= par_mode_d;
      par_bit_q     <= par_bit_d;
      stop2_q       <= stop2_d;
      hold_data_q   <= hold_data_d;
      hold_parity_q <= hold_parity_d;
      hold_stop2_q  <= hold_stop2_d;
      hold_full_q   <= hold_full_d;
      txd_q         <= txd_d;
      baud_active_q <= baud_active_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a table of hand-derived frames,
// directed multi-cycle corner cases, and randomized traffic checked against
// a frame-level reference model (expected line bits built from byte/config).
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       baud_tick;
  logic       baud_active;
  logic       txd;
  logic       busy;
  logic       frame_done;

  uart_tx_ctrl_if bus ();

  uart_tx_ctrl dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .s           (bus),
    .cfg_parity  (cfg_parity),
    .cfg_stop2   (cfg_stop2),
    .baud_tick   (baud_tick),
    .baud_active (baud_active),
    .txd         (txd),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  par;
    logic        stop2;
    int          div;
    logic [11:0] exp;
    int          len;
  } vec_t;

  vec_t  vecs [7];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    div = 4;
  int    gen_cnt = 0;
  bit    idle_noise = 1'b0;
  int    accepted = 0;
  int    done_cnt = 0;
  int    drops = 0;
  string expect_q [$];
  string done_log [$];
  string cur = "";
  string last_frame = "";

  function automatic string bit_str(input logic b);
    string r;
    if (b) r = "1";
    else   r = "0";
    return r;
  endfunction

  // Reference frame: start 0, data LSB first, optional parity, 1 or 2 stops.
  function automatic string build_frame(input logic [7:0] d, input logic [1:0] p, input logic s2);
    string f;
    int    ones;
    f    = "0";
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f    = {f, bit_str(d[i])};
      ones = ones + int'(d[i]);
    end
    if (p == 2'b01) f = {f, bit_str((ones % 2) == 1)};
    else if (p == 2'b10) f = {f, bit_str((ones % 2) == 0)};
    f = {f, "1"};
    if (s2) f = {f, "1"};
    return f;
  endfunction

  // Table expectations are written left-justified, first line bit at bit 11.
  function automatic string bits_to_str(input logic [11:0] e, input int len);
    string f;
    f = "";
    for (int i = 0; i < len; i++) f = {f, bit_str(e[11-i])};
    return f;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %s expected %s at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: record handshakes into the model, emulate the baud generator,
  // collect line bits per tick, score finished frames, check invariants.
  task automatic clock_cycle();
    logic       hs;
    logic       ba_prev;
    logic [7:0] d;
    logic [1:0] p;
    logic       s2;
    int         outstanding;
    hs      = bus.s_valid && bus.s_ready;
    d       = bus.s_data;
    p       = cfg_parity;
    s2      = cfg_stop2;
    ba_prev = baud_active;
    @(posedge clk);
    #1;
    if (hs) begin
      expect_q.push_back(build_frame(d, p, s2));
      accepted++;
    end
    if (ba_prev) gen_cnt = (gen_cnt + 1) % div;
    else         gen_cnt = 0;
    baud_tick = ba_prev && (gen_cnt == div - 1);
    if (idle_noise && !baud_active) baud_tick = ($urandom_range(0, 1) == 1);
    if (frame_done) begin
      done_cnt++;
      last_frame = cur;
      done_log.push_back(cur);
      cur = "";
      check_output("frame_done_expected", expect_q.size() > 0, 1);
      if (expect_q.size() > 0) check_str("frame_bits", last_frame, expect_q.pop_front());
    end
    if (baud_tick && baud_active) cur = {cur, bit_str(txd)};
    if (ba_prev && !baud_active) drops++;
    outstanding = accepted - done_cnt;
    check_output("busy", busy, outstanding != 0);
    if (outstanding == 0) begin
      check_output("idle_active", baud_active, 0);
      check_output("idle_ready", bus.s_ready, 1);
      check_output("idle_txd", txd, 1);
    end
    if (outstanding >= 2) check_output("full_ready", bus.s_ready, 0);
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic [1:0] p, input logic s2);
    int start;
    int guard;
    start = accepted;
    guard = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    cfg_parity  = p;
    cfg_stop2   = s2;
    while (accepted == start && guard < 500) begin
      clock_cycle();
      guard++;
    end
    bus.s_valid = 1'b0;
    check_output("accept_within_budget", accepted - start, 1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int guard;
    guard = 0;
    while (done_cnt < target && guard < budget) begin
      clock_cycle();
      guard++;
    end
    check_output("done_within_budget", done_cnt >= target, 1);
  endtask

  task automatic clear_model();
    expect_q.delete();
    done_log.delete();
    cur        = "";
    accepted   = 0;
    done_cnt   = 0;
    drops      = 0;
    gen_cnt    = 0;
    baud_tick  = 1'b0;
  endtask

  // Hard stop in case the run wedges somewhere unbounded.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   start_drops;
    int   n;
    int   guard;

    vecs[0] = '{8'h55, 2'b00, 1'b0, 4, 12'b0101010101_00, 10};
    vecs[1] = '{8'hA3, 2'b01, 1'b0, 3, 12'b01100010101_0, 11};
    vecs[2] = '{8'hA3, 2'b10, 1'b0, 5, 12'b01100010111_0, 11};
    vecs[3] = '{8'h00, 2'b00, 1'b1, 2, 12'b00000000011_0, 11};
    vecs[4] = '{8'hFF, 2'b10, 1'b1, 4, 12'b011111111111, 12};
    vecs[5] = '{8'h80, 2'b11, 1'b0, 6, 12'b0000000011_00, 10};
    vecs[6] = '{8'h6B, 2'b01, 1'b1, 3, 12'b011010110111, 12};

    arst_n      = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    cfg_parity  = 2'b00;
    cfg_stop2   = 1'b0;
    baud_tick   = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_txd", txd, 1);
    check_output("rst_active", baud_active, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", frame_done, 0);
    check_output("rst_ready", bus.s_ready, 1);
    arst_n = 1'b1;
    repeat (2) clock_cycle();

    $display("[TB] table vectors");
    idle_noise = 1'b1;
    for (int i = 0; i < 7; i++) begin
      div     = vecs[i].div;
      gen_cnt = 0;
      apply_stimulus(vecs[i].data, vecs[i].par, vecs[i].stop2);
      if (i == 0) begin
        check_output("ready_low_after_accept", bus.s_ready, 0);
        check_output("txd_high_one_edge", txd, 1);
        clock_cycle();
        check_output("txd_low_two_edges", txd, 0);
      end
      wait_done(done_cnt + 1, 40 * vecs[i].div);
      check_str("vector_frame", last_frame, bits_to_str(vecs[i].exp, vecs[i].len));
      check_output("vector_done_pulse", frame_done, 1);
      check_output("vector_active_fell", baud_active, 0);
      clock_cycle();
      check_output("vector_done_one_cycle", frame_done, 0);
    end

    $display("[TB] back-to-back frames");
    div = 3;
    start_drops = drops;
    apply_stimulus(8'h01, 2'b00, 1'b0);
    apply_stimulus(8'h80, 2'b00, 1'b0);
    check_output("b2b_ready_low", bus.s_ready, 0);
    wait_done(done_cnt + 2, 200);
    n = done_log.size();
    check_str("b2b_first", done_log[n-2], "0100000001");
    check_str("b2b_second", done_log[n-1], "0000000011");
    check_output("b2b_single_drop", drops - start_drops, 1);
    repeat (3) clock_cycle();

    $display("[TB] parity change mid-frame");
    div = 4;
    apply_stimulus(8'h3C, 2'b00, 1'b0);
    cfg_parity = 2'b01;
    repeat (10) clock_cycle();
    apply_stimulus(8'h3C, 2'b01, 1'b0);
    wait_done(done_cnt + 2, 300);
    n = done_log.size();
    check_str("par_switch_old", done_log[n-2], "0001111001");
    check_str("par_switch_new", done_log[n-1], "00011110001");
    repeat (3) clock_cycle();

    $display("[TB] reset during data bit 4");
    apply_stimulus(8'hC5, 2'b01, 1'b0);
    guard = 0;
    while (cur.len() < 5 && guard < 200) begin
      clock_cycle();
      guard++;
    end
    check_output("reached_data_bit4", cur.len(), 5);
    clock_cycle();
    #3;
    arst_n = 1'b0;
    #1;
    check_output("midrst_txd", txd, 1);
    check_output("midrst_active", baud_active, 0);
    check_output("midrst_ready", bus.s_ready, 1);
    check_output("midrst_busy", busy, 0);
    clear_model();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_output("midrst_no_done", frame_done, 0);
    end
    arst_n = 1'b1;
    repeat (2) clock_cycle();
    apply_stimulus(8'h5A, 2'b10, 1'b1);
    wait_done(1, 200);
    check_str("after_reset_frame", last_frame, "001011010111");
    check_output("after_reset_count", done_cnt, 1);
    repeat (3) clock_cycle();

    $display("[TB] randomized traffic");
    for (int b = 0; b < 3; b++) begin
      div = 2 + b;
      for (int c = 0; c < 600; c++) begin
        cfg_parity  = 2'($urandom_range(0, 3));
        cfg_stop2   = 1'($urandom_range(0, 1));
        bus.s_valid = ($urandom_range(0, 3) == 0);
        bus.s_data  = 8'($urandom_range(0, 255));
        clock_cycle();
      end
      bus.s_valid = 1'b0;
      wait_done(accepted, 3000);
      repeat (3) clock_cycle();
    end
    check_output("drain_expect_empty", expect_q.size(), 0);
    check_output("drain_no_partial", cur.len(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-002 SHALL have port: arst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: s_valid  input  1  byte offered by requester.
REQ-004 SHALL have port: s_ready  output  1  block can accept a byte this cycle.
REQ-005 SHALL have port: s_data  input  8  byte to send, LSB first on line.
REQ-006 SHALL have port: cfg_parity  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-007 SHALL have port: cfg_stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-008 SHALL have port: baud_tick  input  1  1x baud enable pulse from baud generator (one clk wide).
REQ-009 SHALL have port: baud_active  output  1  run request to baud generator; generator counter is held cleared while low.
REQ-010 SHALL have port: txd  output  1  serial line, idle high.
REQ-011 SHALL have port: busy  output  1  high whenever state is not IDLE or holding register is full.
REQ-012 SHALL have port: frame_done  output  1  one-cycle pulse at end of last stop bit.

Function
REQ-013 SHALL contain a one-entry holding register (hold_data, hold_parity, hold_stop2, hold_full); s_ready = !hold_full, registered-path only.
REQ-014 SHALL on s_valid && s_ready at edge N load s_data, cfg_parity, cfg_stop2 into holding register and set hold_full after edge N.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL in IDLE with hold_full move to START on next edge, move holding contents into shift/config registers and clear hold_full in the same edge; txd low from the second edge after the handshake.
REQ-017 SHALL drive baud_active = 1 in every state except IDLE, 0 in IDLE.
REQ-018 SHALL change state/bit only on cycles with baud_tick = 1; baud_tick in IDLE is ignored.
REQ-019 SHALL drive txd: IDLE 1, START 0, DATA shift_reg[0], PARITY computed bit, STOP 1.
REQ-020 SHALL leave START for DATA on tick; in DATA shift right and increment 3-bit bit counter each tick; after the 8th data tick go to PARITY if latched parity is 01/10, else STOP.
REQ-021 SHALL compute parity from latched byte: even = XOR of 8 bits, odd = inverted XOR.
REQ-022 SHALL hold STOP for 1 tick (stop2 = 0) or 2 ticks (stop2 = 1), using a stop counter.
REQ-023 SHALL on the final STOP tick pulse frame_done for one cycle and go to START if hold_full (baud_active stays 1, no idle gap), else to IDLE.
REQ-024 SHALL latch configuration at handshake; cfg_* changes during a frame do not affect it.
REQ-025 SHALL allow a new handshake while a frame is in flight if hold_full = 0.
REQ-026 SHALL keep frame length exactly 1 + 8 + P + S ticks (P in {0,1}, S in {1,2}).

Reset
REQ-027 SHALL on arst_n low, immediately and regardless of state: state IDLE, txd 1, baud_active 0, busy 0, frame_done 0, hold_full 0 (s_ready 1), counters and shift register 0.
REQ-028 SHALL discard any partially sent frame and held byte on reset; no frame_done is produced.

Structure
REQ-029 SHALL take the FSM state enum and parity-mode encoding (PAR_NONE, PAR_EVEN, PAR_ODD) from shared package uart_pkg.
REQ-030 SHALL contain no sub-module; the baud generator is instantiated by the parent, connected via baud_active/baud_tick.

Verification
REQ-031 SHALL cover: 0x55, parity none, 1 stop, baud_tick every 4 clk -> txd per tick 0,1,0,1,0,1,0,1,0,1; frame_done after 10th tick; baud_active falls next edge.
REQ-032 SHALL cover: 0xA3 even parity -> data 1,1,0,0,0,1,0,1, parity bit 0; same byte odd -> parity bit 1; 11 ticks each.
REQ-033 SHALL cover: 0x00, cfg_stop2 = 1 -> txd high for 2 ticks after data, frame is 11 ticks, frame_done only after the second stop tick.
REQ-034 SHALL cover: back-to-back 0x01 then 0x80 offered while first frame active -> s_ready low after second accept, baud_active never drops, START of second frame directly follows last stop tick.
REQ-035 SHALL cover: arst_n asserted during DATA bit 4 -> txd 1 and baud_active 0 same cycle, s_ready 1, no frame_done; next byte after release sent correctly.
REQ-036 SHALL cover: cfg_parity switched 00 -> 01 mid-frame -> current frame has no parity bit; next accepted frame has it.
